// File: rtl/uart_rx_if.sv
// uart_rx serial-side bundle: rx line in, received byte and strobes out.
// slave = receiver, master = whatever drives the line and consumes data.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx,
    input  data, data_valid, frame_err, busy
  );

  modport slave (
    input  rx,
    output data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 2-flop synchroniser, mid-bit sampling,
// one-cycle data_valid / frame_err strobes, no buffering.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  logic rx_s;
  assign rx_s = sync2_q;

  // Synchronise rx and keep a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM: start detect, mid-bit sampling, stop check, strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (prev_q && !rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == LAST_IX) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
